rgb_capture_640x480: RTL and testbench
======================================

Name: rgb_capture_640x480

Overview:
- Video input frame grabber; the receive-side counterpart of the 640x480 RGB timing/scan-out block.
- Samples an incoming 640x480@60 stream (hs/vs/de plus pixel word) and writes each active pixel into video memory at VIDEO_MEM_B + pixel offset.
- Uses the same write_q/write_dn handshake as the external SRAM interface.
- Sits between an external video decoder and the video SRAM port.

Parameters:
- VIDEO_MEM_B, 1, base word address of the capture frame buffer.
- H_ACT, 640, active pixels per line.
- V_ACT, 480, active lines per frame.
- FIFO_DEPTH, 8, pixel FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  system clock; runs at twice the pixel rate.
- rst_  in  1  asynchronous, active-low reset.
- pix_en  in  1  pixel strobe, one clk-wide per pixel; inputs below are valid only when pix_en=1.
- hs  in  1  horizontal sync, active low.
- vs  in  1  vertical sync, active low.
- de  in  1  data enable, high during active pixels.
- pix_data  in  `DATA_SIZE0+1  pixel word.
- arm  in  1  one-cycle pulse; captures one frame.
- cont  in  1  continuous mode, re-arms after each frame.
- busy  out  1  high in any state other than IDLE.
- frame_done  out  1  one-cycle pulse when a frame has been fully written.
- overflow  out  1  sticky; a pixel was dropped because the FIFO was full.
- line_err  out  1  sticky; an active line whose de run length was not H_ACT.
- mem_addr  out  `ADDR_SIZE0+1  write address.
- mem_data  out  `DATA_SIZE0+1  write data.
- mem_write_q  out  1  write request.
- mem_write_dn  in  1  write acknowledge, one-cycle pulse.

Behaviour:
- Reset values: every output is 0 and every counter is 0; state=IDLE.
- Reset is asynchronous and abandons any outstanding request: mem_write_q drops immediately and the FIFO is emptied.
- Input stage:
  - On clk with pix_en=1, register hs, vs, de and pix_data (1 stage). The registered copies are s_hs, s_vs, s_de, s_pix.
  - vs_fall means s_vs went 1->0 between two consecutive samples. sol means s_de went 0->1.
- State machine:
  - IDLE: arm=1 -> WAIT_VS. arm is ignored in every other state.
  - WAIT_VS: on vs_fall, go to CAPTURE and clear pix_cnt, line_cnt and run_cnt.
  - CAPTURE: each sample with s_de=1 pushes {offset=pix_cnt, data=s_pix}, then pix_cnt++.
    - Push happens 1 cycle after the sample, so data reaches the FIFO 2 clk after pix_en.
    - Leave CAPTURE for FLUSH when pix_cnt reaches H_ACT*V_ACT or on vs_fall, whichever comes first.
    - A vs_fall that ends CAPTURE does not start a new frame.
  - FLUSH: wait until the FIFO is empty and mem_write_q=0. Then pulse frame_done for 1 cycle and go to WAIT_VS if cont=1, else IDLE.
- Line checking:
  - run_cnt counts consecutive s_de=1 samples.
  - On s_de 1->0: if run_cnt != H_ACT, set line_err; then line_cnt++ and clear run_cnt.
  - Pixels with line_cnt >= V_ACT are discarded and do not push.
- FIFO:
  - Entries are {offset `ADDR_SIZE0+1, data}.
  - Full on push: drop the pixel and set overflow. pix_cnt still increments, so later pixels keep correct addresses; the dropped pixel leaves a hole in memory.
  - Simultaneous push and pop is allowed when full, if the pop completes in the same cycle.
- Memory handshake:
  - When the FIFO is non-empty and no request is outstanding, drive mem_addr = VIDEO_MEM_B + head.offset and mem_data = head.data, and assert mem_write_q.
  - mem_addr, mem_data and mem_write_q stay stable until mem_write_dn=1 is sampled on a clk edge.
  - On that edge: pop the head and drop mem_write_q for at least 1 cycle. Next request at the earliest 1 cycle later.
  - mem_write_dn while mem_write_q=0 is ignored.
- Address arithmetic: unsigned, widths `ADDR_SIZE0+1, wrap modulo 2^width.
- overflow and line_err clear only on reset or on entry to CAPTURE.

Optional Feature:
- Macro RGB_CAPTURE_STATS_EN.
- When defined, add three outputs:
  - frame_cnt, 16 bits: increments on frame_done.
  - drop_cnt, 16 bits: increments on each dropped pixel; saturates at 0xFFFF.
  - last_lines, 10 bits: line_cnt latched on leaving CAPTURE.
- All three are 0 at reset and are not cleared on entry to CAPTURE.
- When not defined, these ports and their logic do not exist; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - state encoding: IDLE=0, WAIT_VS=1, CAPTURE=2, FLUSH=3;
  - constants H_ACT*V_ACT=307200 and the default H_ACT and V_ACT;
  - the FIFO entry width, derived from the `ADDR_SIZE0/`DATA_SIZE0 macros in sizes.v.
- One sub-module is natural: capture_fifo, a synchronous FIFO with push/pop/full/empty and a parameterised depth and width.

Test Plan:
- Reset and arm, then one full frame with de run=640 on 480 lines and mem_write_dn returned 1 cycle after each request -> 307200 writes at addresses 1..307200, data matches stimulus, one frame_done pulse, overflow=0, line_err=0, busy returns to 0.
- mem_write_dn delayed 40 cycles per write -> overflow=1; writes still land at pixel-exact offsets with holes at the dropped pixels; frame_done still pulses once.
- Line 7 carries a de run of 639 -> line_err=1 and the 639 pixels are still written.
- cont=1 over 3 input frames -> WAIT_VS re-entered after each frame_done; arm pulses while busy have no effect.
- rst_ low while mem_write_q=1 mid-frame -> mem_write_q=0 with no clk edge, then state IDLE and all outputs 0.
- vs_fall after 1000 pixels -> FLUSH; the 1000 queued pixels drain; frame_done pulses.

Source files
------------

// File: rtl/rgb_capture_640x480_pkg.sv
// rtl/rgb_capture_640x480_pkg.sv - shared types and constants for the 640x480 RGB frame grabber
`ifndef ADDR_SIZE0
`define ADDR_SIZE0 18
`endif
`ifndef DATA_SIZE0
`define DATA_SIZE0 15
`endif

package rgb_capture_640x480_pkg;

    localparam int ADDR_W    = `ADDR_SIZE0 + 1;
    localparam int DATA_W    = `DATA_SIZE0 + 1;
    localparam int ENTRY_W   = ADDR_W + DATA_W;
    localparam int H_ACT_DEF = 640;
    localparam int V_ACT_DEF = 480;
    localparam int FRAME_PIX = 307200;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VS = 2'd1,
        CAPTURE = 2'd2,
        FLUSH   = 2'd3
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] offset;
        logic [DATA_W-1:0] data;
    } entry_t;

endpackage

// File: rtl/rgb_capture_640x480_capture_fifo.sv
// rtl/rgb_capture_640x480_capture_fifo.sv - synchronous pixel FIFO, push accepted when full if a pop completes
module rgb_capture_640x480_capture_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_pop;
    logic             do_push;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/rgb_capture_640x480.sv
// rtl/rgb_capture_640x480.sv - 640x480 video frame grabber into SRAM; RGB_CAPTURE_STATS_EN adds frame/drop/line statistics
module rgb_capture_640x480
    import rgb_capture_640x480_pkg::*;
#(
    parameter logic [ADDR_W-1:0] VIDEO_MEM_B = ADDR_W'(1),
    parameter int                H_ACT       = H_ACT_DEF,
    parameter int                V_ACT       = V_ACT_DEF,
    parameter int                FIFO_DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              pix_en,
    input  logic              hs,
    input  logic              vs,
    input  logic              de,
    input  logic [DATA_W-1:0] pix_data,
    input  logic              arm,
    input  logic              cont,
    output logic              busy,
    output logic              frame_done,
    output logic              overflow,
    output logic              line_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_write_q,
    input  logic              mem_write_dn
`ifdef RGB_CAPTURE_STATS_EN
    ,
    output logic [15:0]       frame_cnt,
    output logic [15:0]       drop_cnt,
    output logic [9:0]        last_lines
`endif
);

    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(H_ACT * V_ACT - 1);
    localparam logic [15:0]       H_RUN    = 16'(H_ACT);
    localparam logic [15:0]       V_LIM    = 16'(V_ACT);

    state_t            state;
    logic              s_hs, s_vs, s_de, p_vs, p_de, smp;
    logic [DATA_W-1:0] s_pix;
    logic [ADDR_W-1:0] pix_cnt;
    logic [15:0]       line_cnt;
    logic [15:0]       run_cnt;
    logic              vs_fall, de_fall, push_req, pop, drop, cap_end, flush_done;
    logic              fifo_full, fifo_empty;
    logic [ENTRY_W-1:0] fifo_dout;
    entry_t            head;
    logic              unused_hs;

    assign unused_hs = s_hs;

    // smp marks the cycle after a strobe, when s_* hold the new sample and p_* the previous one
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            smp   <= 1'b0;
            s_hs  <= 1'b0;
            s_vs  <= 1'b0;
            s_de  <= 1'b0;
            s_pix <= '0;
            p_vs  <= 1'b0;
            p_de  <= 1'b0;
        end else begin
            smp <= pix_en;
            if (pix_en) begin
                p_vs  <= s_vs;
                p_de  <= s_de;
                s_hs  <= hs;
                s_vs  <= vs;
                s_de  <= de;
                s_pix <= pix_data;
            end
        end
    end

    assign vs_fall    = smp & p_vs & ~s_vs;
    assign de_fall    = smp & p_de & ~s_de;
    assign push_req   = (state == CAPTURE) & smp & s_de & (line_cnt < V_LIM);
    assign pop        = mem_write_q & mem_write_dn;
    assign drop       = push_req & fifo_full & ~pop;
    assign cap_end    = (state == CAPTURE) & (vs_fall | (push_req & (pix_cnt == LAST_PIX)));
    assign flush_done = (state == FLUSH) & fifo_empty & ~mem_write_q;
    assign head       = entry_t'(fifo_dout);

    rgb_capture_640x480_capture_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst_      (rst_),
        .push      (push_req),
        .push_data ({pix_cnt, s_pix}),
        .pop       (pop),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state      <= IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
            line_err   <= 1'b0;
            pix_cnt    <= '0;
            line_cnt   <= '0;
            run_cnt    <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (arm) begin
                        state <= WAIT_VS;
                        busy  <= 1'b1;
                    end
                end
                WAIT_VS: begin
                    if (vs_fall) begin
                        state    <= CAPTURE;
                        pix_cnt  <= '0;
                        line_cnt <= '0;
                        run_cnt  <= '0;
                        overflow <= 1'b0;
                        line_err <= 1'b0;
                    end
                end
                CAPTURE: begin
                    // pix_cnt advances even on a drop so later pixels keep their true offsets
                    if (push_req) pix_cnt <= pix_cnt + ADDR_W'(1);
                    if (drop)     overflow <= 1'b1;
                    if (smp && s_de) begin
                        run_cnt <= run_cnt + 16'd1;
                    end else if (de_fall) begin
                        if (run_cnt != H_RUN) line_err <= 1'b1;
                        line_cnt <= line_cnt + 16'd1;
                        run_cnt  <= '0;
                    end
                    if (cap_end) state <= FLUSH;
                end
                FLUSH: begin
                    if (flush_done) begin
                        frame_done <= 1'b1;
                        if (cont) begin
                            state <= WAIT_VS;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            mem_write_q <= 1'b0;
            mem_addr    <= '0;
            mem_data    <= '0;
        end else if (mem_write_q) begin
            if (mem_write_dn) mem_write_q <= 1'b0;
        end else if (!fifo_empty) begin
            mem_write_q <= 1'b1;
            mem_addr    <= VIDEO_MEM_B + head.offset;
            mem_data    <= head.data;
        end
    end

`ifdef RGB_CAPTURE_STATS_EN
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            frame_cnt  <= '0;
            drop_cnt   <= '0;
            last_lines <= '0;
        end else begin
            if (flush_done) frame_cnt <= frame_cnt + 16'd1;
            if (drop && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
            if (cap_end) last_lines <= line_cnt[9:0];
        end
    end
`endif

endmodule

// File: tb/tb_rgb_capture_640x480.sv
// tb/tb_rgb_capture_640x480.sv - scoreboard bench for rgb_capture_640x480 on a reduced 16x6 raster
module tb_rgb_capture_640x480;
    import rgb_capture_640x480_pkg::*;

    localparam int H  = 16;
    localparam int V  = 6;
    localparam int FD = 4;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } exp_t;

    logic              clk, rst_, pix_en, hs, vs, de, arm, cont, mem_write_dn;
    logic [DATA_W-1:0] pix_data;
    logic              busy, frame_done, overflow, line_err, mem_write_q;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
`ifdef RGB_CAPTURE_STATS_EN
    logic [15:0]       frame_cnt, drop_cnt;
    logic [9:0]        last_lines;
`endif

    exp_t exp_q[$];
    int   n_cmp, n_fail, n_done, holes, dn_delay;
    bit   hole_mode, exp_en;

    rgb_capture_640x480 #(
        .VIDEO_MEM_B (ADDR_W'(1)),
        .H_ACT       (H),
        .V_ACT       (V),
        .FIFO_DEPTH  (FD)
    ) dut (
        .clk          (clk),
        .rst_         (rst_),
        .pix_en       (pix_en),
        .hs           (hs),
        .vs           (vs),
        .de           (de),
        .pix_data     (pix_data),
        .arm          (arm),
        .cont         (cont),
        .busy         (busy),
        .frame_done   (frame_done),
        .overflow     (overflow),
        .line_err     (line_err),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .mem_write_q  (mem_write_q),
        .mem_write_dn (mem_write_dn)
`ifdef RGB_CAPTURE_STATS_EN
        ,
        .frame_cnt    (frame_cnt),
        .drop_cnt     (drop_cnt),
        .last_lines   (last_lines)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic logic [DATA_W-1:0] pdata(input int fid, input int idx);
        return DATA_W'(fid * 4096 + idx * 37 + 5);
    endfunction

    // memory responder: acknowledge each request dn_delay cycles after it appears
    initial begin
        mem_write_dn = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_ && mem_write_q && !mem_write_dn) begin
                repeat (dn_delay - 1) @(negedge clk);
                if (rst_ && mem_write_q) begin
                    mem_write_dn = 1'b1;
                    @(negedge clk);
                    mem_write_dn = 1'b0;
                end
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (frame_done) n_done++;
            if (rst_ && mem_write_q && mem_write_dn) begin
                if (hole_mode)
                    while (exp_q.size() > 0 && exp_q[0].addr != mem_addr) begin
                        void'(exp_q.pop_front());
                        holes++;
                    end
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL write_unexpected: got addr %0h data %0h, expected no write", mem_addr, mem_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("write_addr_data", {mem_addr, mem_data}, {e.addr, e.data});
                end
            end
        end
    end

    task automatic pix(input logic h, input logic v, input logic d, input logic [DATA_W-1:0] px);
        @(negedge clk);
        pix_en = 1'b1; hs = h; vs = v; de = d; pix_data = px;
        @(negedge clk);
        pix_en = 1'b0;
    endtask

    task automatic vsync();
        repeat (2) pix(1'b1, 1'b1, 1'b0, '0);
        repeat (3) pix(1'b1, 1'b0, 1'b0, '0);
        repeat (3) pix(1'b1, 1'b1, 1'b0, '0);
    endtask

    task automatic gen_frame(input int fid, input int short_line, input int max_pix);
        int idx;
        int run;
        idx = 0;
        vsync();
        for (int l = 0; l < V; l++) begin
            run = (l == short_line) ? H - 1 : H;
            for (int p = 0; p < run; p++) begin
                if (idx == max_pix) return;
                if (exp_en) exp_q.push_back({ADDR_W'(1 + idx), pdata(fid, idx)});
                pix(1'b1, 1'b1, 1'b1, pdata(fid, idx));
                idx++;
            end
            pix(1'b0, 1'b1, 1'b0, '0);
            pix(1'b0, 1'b1, 1'b0, '0);
            pix(1'b1, 1'b1, 1'b0, '0);
            pix(1'b1, 1'b1, 1'b0, '0);
        end
        repeat (6) pix(1'b1, 1'b1, 1'b0, '0);
    endtask

    task automatic arm_pulse();
        @(negedge clk); arm = 1'b1;
        @(negedge clk); arm = 1'b0;
    endtask

    task automatic wait_frames(input int target, input int limit);
        int c;
        c = 0;
        while (n_done < target && c < limit) begin
            @(negedge clk);
            c++;
        end
        if (n_done < target) begin
            n_cmp++;
            n_fail++;
            $display("FAIL wait_frame_done: got %0d pulses, expected %0d", n_done, target);
        end
        repeat (6) @(negedge clk);
    endtask

    initial begin
        int c;
        rst_ = 1'b0; pix_en = 1'b0; hs = 1'b1; vs = 1'b1; de = 1'b0; pix_data = '0;
        arm = 1'b0; cont = 1'b0; dn_delay = 1; hole_mode = 1'b0; exp_en = 1'b1;
        n_cmp = 0; n_fail = 0; n_done = 0; holes = 0;

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_line_err", line_err, 0);
        chk("rst_mem_write_q", mem_write_q, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_data", mem_data, 0);
        rst_ = 1'b1;
        repeat (2) @(negedge clk);

        // full frame, immediate acknowledge
        arm_pulse();
        chk("t1_busy_after_arm", busy, 1);
        gen_frame(1, -1, 100000);
        wait_frames(1, 2000);
        chk("t1_frame_done_count", n_done, 1);
        chk("t1_queue_empty", exp_q.size(), 0);
        chk("t1_overflow", overflow, 0);
        chk("t1_line_err", line_err, 0);
        chk("t1_busy_idle", busy, 0);

        // short line 2 (15 pixels); next vsync closes the capture
        n_done = 0;
        arm_pulse();
        gen_frame(2, 2, 100000);
        vsync();
        wait_frames(1, 2000);
        chk("t3_frame_done_count", n_done, 1);
        chk("t3_queue_empty", exp_q.size(), 0);
        chk("t3_line_err", line_err, 1);
        chk("t3_overflow", overflow, 0);
        chk("t3_busy_idle", busy, 0);

        // slow memory: drops leave holes, surviving pixels land at exact offsets
        n_done = 0; holes = 0; hole_mode = 1'b1; dn_delay = 40;
        arm_pulse();
        gen_frame(3, -1, 100000);
        wait_frames(1, 8000);
        holes += exp_q.size();
        exp_q.delete();
        chk("t2_frame_done_count", n_done, 1);
        chk("t2_overflow", overflow, 1);
        chk("t2_holes_present", holes > 0, 1);
        chk("t2_line_err", line_err, 0);
        hole_mode = 1'b0; dn_delay = 1;

        // early vsync after 40 pixels ends the frame; partial last line flags line_err
        n_done = 0;
        arm_pulse();
        gen_frame(4, -1, 40);
        vsync();
        wait_frames(1, 2000);
        chk("t6_frame_done_count", n_done, 1);
        chk("t6_queue_empty", exp_q.size(), 0);
        chk("t6_overflow", overflow, 0);
        chk("t6_line_err", line_err, 1);
        chk("t6_busy_idle", busy, 0);

        // continuous mode over three frames with stray arm pulses
        n_done = 0; cont = 1'b1;
        arm_pulse();
        gen_frame(5, -1, 100000);
        arm_pulse();
        gen_frame(6, -1, 100000);
        arm_pulse();
        gen_frame(7, -1, 100000);
        wait_frames(3, 3000);
        chk("t4_frame_done_count", n_done, 3);
        chk("t4_queue_empty", exp_q.size(), 0);
        chk("t4_busy_wait_vs", busy, 1);
        chk("t4_line_err", line_err, 0);
        cont = 1'b0;

        // asynchronous reset while a write is outstanding
        dn_delay = 10;
        gen_frame(8, -1, 6);
        c = 0;
        while (!mem_write_q && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk("t5_req_pending", mem_write_q, 1);
        #2;
        rst_ = 1'b0;
        exp_q.delete();
        #1;
        chk("t5_q_async_drop", mem_write_q, 0);
        repeat (2) @(negedge clk);
        chk("t5_busy", busy, 0);
        chk("t5_frame_done", frame_done, 0);
        chk("t5_overflow", overflow, 0);
        chk("t5_line_err", line_err, 0);
        chk("t5_mem_addr", mem_addr, 0);
        chk("t5_mem_data", mem_data, 0);
        rst_ = 1'b1;
        repeat (4) @(negedge clk);
        chk("t5_idle_after_release", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
